// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate data cache (one word per line)
// between the MEM stage and the SRAM controller; ready drives the pipeline freeze.
module cache_controller #(
    parameter int INDEX_W = 6,
    parameter int ADDR_W  = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        sram_r_en,
    output logic        sram_w_en,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    input  logic        sram_ready
);

    localparam int SETS  = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    typedef enum logic [1:0] {IDLE, RMISS, WRITE} state_t;

    state_t state, next_state;

    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               unused_bits;

    logic [SETS-1:0]  valid0, valid1, lru;
    logic [TAG_W-1:0] tag0  [SETS];
    logic [TAG_W-1:0] tag1  [SETS];
    logic [31:0]      data0 [SETS];
    logic [31:0]      data1 [SETS];

    logic hit0, hit1, hit, victim;
    logic fill_en, upd_en, upd_way, lru_en, lru_val;

    assign index       = address[INDEX_W+1:2];
    assign tag         = address[ADDR_W-1:INDEX_W+2];
    assign unused_bits = ^{address[31:ADDR_W], address[1:0]};

    assign hit0 = valid0[index] && (tag0[index] == tag);
    assign hit1 = valid1[index] && (tag1[index] == tag);
    assign hit  = hit0 | hit1;

    // Fill an empty way first; only evict the LRU way when both are valid.
    assign victim = !valid0[index] ? 1'b0 : (!valid1[index] ? 1'b1 : lru[index]);

    assign sram_r_en  = (state == RMISS);
    assign sram_w_en  = (state == WRITE);
    assign sram_addr  = address;
    assign sram_wdata = wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        rdata      = 32'd0;
        fill_en    = 1'b0;
        upd_en     = 1'b0;
        upd_way    = 1'b0;
        lru_en     = 1'b0;
        lru_val    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_w_en) begin
                    next_state = WRITE;
                end else if (mem_r_en) begin
                    if (hit) begin
                        ready   = 1'b1;
                        rdata   = hit0 ? data0[index] : data1[index];
                        lru_en  = 1'b1;
                        lru_val = hit0;
                    end else begin
                        next_state = RMISS;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            RMISS: begin
                ready = sram_ready;
                if (sram_ready) begin
                    rdata      = sram_rdata;
                    fill_en    = 1'b1;
                    lru_en     = 1'b1;
                    lru_val    = ~victim;
                    next_state = IDLE;
                end
            end
            WRITE: begin
                ready = sram_ready;
                if (sram_ready) begin
                    if (hit) begin
                        upd_en  = 1'b1;
                        upd_way = hit1;
                        lru_en  = 1'b1;
                        lru_val = hit0;
                    end
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid0 <= '0;
            valid1 <= '0;
            lru    <= '0;
        end else begin
            if (fill_en) begin
                if (victim) valid1[index] <= 1'b1;
                else        valid0[index] <= 1'b1;
            end
            if (lru_en) lru[index] <= lru_val;
        end
    end

    // Tag and data arrays need no reset: they are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            if (victim) begin
                tag1[index]  <= tag;
                data1[index] <= sram_rdata;
            end else begin
                tag0[index]  <= tag;
                data0[index] <= sram_rdata;
            end
        end else if (upd_en) begin
            if (upd_way) data1[index] <= wdata;
            else         data0[index] <= wdata;
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: a scripted SRAM stub strobes sram_ready
// after a chosen number of cycles; expectations are hand-computed per vector.
module tb_cache_controller;

    logic        clk;
    logic        rst;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        sram_r_en;
    logic        sram_w_en;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_ready;

    int n_checks = 0;
    int n_fail   = 0;

    cache_controller dut (
        .clk        (clk),
        .rst        (rst),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .address    (address),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .sram_r_en  (sram_r_en),
        .sram_w_en  (sram_w_en),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_ready (sram_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, required finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_r_en   = 1'b0;
        mem_w_en   = 1'b0;
        sram_ready = 1'b0;
        sram_rdata = 32'd0;
    endtask

    // lat = number of cycles ready stays low, counting the request cycle in IDLE
    task automatic read_miss(input logic [31:0] addr, input int lat, input logic [31:0] data);
        @(negedge clk);
        address  = addr;
        mem_r_en = 1'b1;
        mem_w_en = 1'b0;
        #1;
        chk("rmiss_req_ready", {31'd0, ready}, 32'd0);
        chk("rmiss_req_sram_r_en", {31'd0, sram_r_en}, 32'd0);
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            #1;
            chk("rmiss_wait_ready", {31'd0, ready}, 32'd0);
            chk("rmiss_wait_sram_r_en", {31'd0, sram_r_en}, 32'd1);
            chk("rmiss_wait_rdata", rdata, 32'd0);
        end
        @(negedge clk);
        sram_ready = 1'b1;
        sram_rdata = data;
        #1;
        chk("rmiss_done_ready", {31'd0, ready}, 32'd1);
        chk("rmiss_done_rdata", rdata, data);
        chk("rmiss_sram_addr", sram_addr, addr);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("rmiss_drop_sram_r_en", {31'd0, sram_r_en}, 32'd0);
    endtask

    task automatic read_hit(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        address  = addr;
        mem_r_en = 1'b1;
        mem_w_en = 1'b0;
        #1;
        chk("rhit_ready", {31'd0, ready}, 32'd1);
        chk("rhit_rdata", rdata, data);
        chk("rhit_sram_r_en", {31'd0, sram_r_en}, 32'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("rhit_after_sram_r_en", {31'd0, sram_r_en}, 32'd0);
    endtask

    task automatic write_op(input logic [31:0] addr, input logic [31:0] data,
                            input int lat, input logic both);
        @(negedge clk);
        address  = addr;
        wdata    = data;
        mem_w_en = 1'b1;
        mem_r_en = both;
        #1;
        chk("wr_req_ready", {31'd0, ready}, 32'd0);
        chk("wr_sram_wdata", sram_wdata, data);
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            #1;
            chk("wr_wait_sram_w_en", {31'd0, sram_w_en}, 32'd1);
            chk("wr_wait_sram_r_en", {31'd0, sram_r_en}, 32'd0);
            chk("wr_wait_ready", {31'd0, ready}, 32'd0);
            chk("wr_wait_sram_wdata", sram_wdata, data);
        end
        @(negedge clk);
        sram_ready = 1'b1;
        #1;
        chk("wr_done_ready", {31'd0, ready}, 32'd1);
        chk("wr_done_rdata", rdata, 32'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("wr_drop_sram_w_en", {31'd0, sram_w_en}, 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        address = 32'd0;
        wdata   = 32'd0;
        idle_inputs();
        #1;
        chk("reset_ready", {31'd0, ready}, 32'd1);
        chk("reset_sram_r_en", {31'd0, sram_r_en}, 32'd0);
        chk("reset_sram_w_en", {31'd0, sram_w_en}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic miss then hit
        read_miss(32'h0000_0400, 5, 32'hDEAD_BEEF);
        read_hit (32'h0000_0400, 32'hDEAD_BEEF);

        // Write hit updates the line
        write_op (32'h0000_0400, 32'h1234_5678, 3, 1'b0);
        read_hit (32'h0000_0400, 32'h1234_5678);

        // Write miss does not allocate
        write_op (32'h0000_0800, 32'h55AA_55AA, 2, 1'b0);
        read_miss(32'h0000_0800, 2, 32'h0BAD_F00D);

        // Different set stays independent
        read_miss(32'h0000_0404, 1, 32'hA5A5_0001);
        read_hit (32'h0000_0404, 32'hA5A5_0001);
        read_hit (32'h0000_0400, 32'h1234_5678);

        // LRU replacement from a clean cache
        pulse_reset();
        read_miss(32'h0000_0400, 2, 32'h1111_1111);
        read_miss(32'h0000_0800, 2, 32'h2222_2222);
        read_hit (32'h0000_0400, 32'h1111_1111);
        read_miss(32'h0000_0C00, 2, 32'h3333_3333);
        read_hit (32'h0000_0400, 32'h1111_1111);
        read_hit (32'h0000_0C00, 32'h3333_3333);
        read_miss(32'h0000_0800, 3, 32'h4444_4444);
        read_hit (32'h0000_0C00, 32'h3333_3333);
        read_hit (32'h0000_0800, 32'h4444_4444);

        // Reset in the middle of a read miss
        @(negedge clk);
        address  = 32'h0000_1000;
        mem_r_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mid_rmiss_sram_r_en", {31'd0, sram_r_en}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_sram_r_en", {31'd0, sram_r_en}, 32'd0);
        chk("async_rst_ready", {31'd0, ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        read_miss(32'h0000_0C00, 2, 32'h5555_5555);

        // Both enables: write takes priority
        write_op (32'h0000_0400, 32'h6666_6666, 4, 1'b1);
        read_hit (32'h0000_0C00, 32'h5555_5555);

        // sram_ready ignored while idle
        @(negedge clk);
        sram_ready = 1'b1;
        #1;
        chk("idle_strobe_sram_r_en", {31'd0, sram_r_en}, 32'd0);
        chk("idle_strobe_ready", {31'd0, ready}, 32'd1);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("idle_strobe_sram_w_en", {31'd0, sram_w_en}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
